// File: rtl/pipe_fwd.sv
// pipe_fwd: three-stage register-register ALU pipeline (operand fetch, execute,
// writeback) with full operand forwarding and a registered memory read port.
module pipe_fwd #(
  parameter int DATA_W    = 16,
  parameter int NREG      = 16,
  parameter int MEM_DEPTH = 256,
  localparam int RW = $clog2(NREG),
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int SW = $clog2(DATA_W)
) (
  input  logic              clk_1,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [RW-1:0]     RS_1,
  input  logic [RW-1:0]     RS_2,
  input  logic [RW-1:0]     RD,
  input  logic [2:0]        func,
  input  logic [AW-1:0]     addr,
  output logic [DATA_W-1:0] z,
  output logic              out_valid,
  output logic [AW-1:0]     out_addr,
  input  logic [AW-1:0]     mrd_addr,
  output logic [DATA_W-1:0] mrd_data
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  logic [DATA_W-1:0] regbank [NREG];
  logic [DATA_W-1:0] mem     [MEM_DEPTH];

  // ID/EX
  logic              v1;
  logic [DATA_W-1:0] a_q, b_q;
  alu_op_e           func_q;
  logic [RW-1:0]     rd_idex;
  logic [AW-1:0]     addr_idex;

  // EX/WB
  logic              v2;
  logic [DATA_W-1:0] r_exwb;
  logic [RW-1:0]     rd_exwb;
  logic [AW-1:0]     addr_exwb;

  logic [DATA_W-1:0] alu_r;
  logic [DATA_W-1:0] a_fwd, b_fwd;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    alu_r = '0;
    case (func_q)
      OP_ADD: alu_r = a_q + b_q;
      OP_SUB: alu_r = a_q - b_q;
      OP_MUL: alu_r = a_q * b_q;
      OP_AND: alu_r = a_q & b_q;
      OP_OR:  alu_r = a_q | b_q;
      OP_XOR: alu_r = a_q ^ b_q;
      OP_SHL: alu_r = a_q << b_q[SW-1:0];
      OP_SHR: alu_r = a_q >> b_q[SW-1:0];
      default: alu_r = '0;
    endcase
  end

  // The youngest in-flight producer wins: the instruction in execute beats
  // the one in writeback, which beats the register bank.
  always_comb begin
    a_fwd = regbank[RS_1];
    if (v1 && rd_idex == RS_1)      a_fwd = alu_r;
    else if (v2 && rd_exwb == RS_1) a_fwd = r_exwb;
  end

  always_comb begin
    b_fwd = regbank[RS_2];
    if (v1 && rd_idex == RS_2)      b_fwd = alu_r;
    else if (v2 && rd_exwb == RS_2) b_fwd = r_exwb;
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      func_q    <= OP_ADD;
      rd_idex   <= '0;
      addr_idex <= '0;
      v2        <= 1'b0;
      r_exwb    <= '0;
      rd_exwb   <= '0;
      addr_exwb <= '0;
      out_valid <= 1'b0;
      z         <= '0;
      out_addr  <= '0;
      mrd_data  <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        a_q       <= a_fwd;
        b_q       <= b_fwd;
        func_q    <= alu_op_e'(func);
        rd_idex   <= RD;
        addr_idex <= addr;
      end
      v2        <= v1;
      r_exwb    <= alu_r;
      rd_exwb   <= rd_idex;
      addr_exwb <= addr_idex;
      out_valid <= v2;
      if (v2) begin
        z        <= r_exwb;
        out_addr <= addr_exwb;
      end
      mrd_data <= mem[mrd_addr];
    end
  end

  // NOTE: storage arrays have no reset; in-flight writes are suppressed because v2 clears asynchronously.
  always_ff @(posedge clk_1) begin
    if (v2) begin
      regbank[rd_exwb] <= r_exwb;
      mem[addr_exwb]   <= r_exwb;
    end
  end

endmodule
